// File: rtl/ibis_video_pkg.sv
// Shared types and constants for the IBIS video timing generator:
// per-axis region enum, control-bit indices, 640x480@60 default timing.
package ibis_video_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } region_e;

  localparam int CTRL_HSYNC = 0;
  localparam int CTRL_VSYNC = 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Colour-bar palette, left to right
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    c = 24'h000000;
    unique case (idx)
      3'd0: c = 24'hFFFFFF;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h00FFFF;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'hFF00FF;
      3'd5: c = 24'hFF0000;
      3'd6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ibis_video_timing_if.sv
// Video timing output bundle; master = timing generator, slave = encoder.
// rgb exists only when IBIS_VIDEO_TIMING_PATTERN_EN is defined.
interface ibis_video_timing_if;
  logic        data_enable;
  logic [1:0]  control;
  logic [11:0] x;
  logic [11:0] y;
  logic        line_start;
  logic        frame_start;
`ifdef IBIS_VIDEO_TIMING_PATTERN_EN
  logic [23:0] rgb;
`endif

  modport master (
    output data_enable, control, x, y, line_start, frame_start
`ifdef IBIS_VIDEO_TIMING_PATTERN_EN
    , output rgb
`endif
  );

  modport slave (
    input data_enable, control, x, y, line_start, frame_start
`ifdef IBIS_VIDEO_TIMING_PATTERN_EN
    , input rgb
`endif
  );
endinterface

// File: rtl/ibis_video_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
// Advances only when adv_i is high.
module ibis_video_axis_counter
  import ibis_video_pkg::*;
#(
  parameter int A_W = 640,
  parameter int F_W = 16,
  parameter int S_W = 96,
  parameter int B_W = 48
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  output logic [11:0] cnt_o,
  output region_e     region_o
);

  localparam int TOTAL = A_W + F_W + S_W + B_W;

  logic [11:0] cnt_q, cnt_d;
  region_e     region_q, region_d;
  logic        last;

  assign last = (cnt_q == 12'(TOTAL - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      region_q <= ACTIVE;
    end else begin
      cnt_q    <= cnt_d;
      region_q <= region_d;
    end
  end

  // Each region ends on its last position; the FSM moves with the counter
  always_comb begin
    cnt_d    = cnt_q;
    region_d = region_q;
    if (adv_i) begin
      cnt_d = last ? 12'd0 : cnt_q + 12'd1;
      unique case (region_q)
        ACTIVE: if (cnt_q == 12'(A_W - 1))             region_d = FRONT;
        FRONT:  if (cnt_q == 12'(A_W + F_W - 1))       region_d = SYNC;
        SYNC:   if (cnt_q == 12'(A_W + F_W + S_W - 1)) region_d = BACK;
        BACK:   if (last)                              region_d = ACTIVE;
        default:                                       region_d = ACTIVE;
      endcase
    end
  end

  assign cnt_o    = cnt_q;
  assign region_o = region_q;

endmodule

// File: rtl/ibis_video_timing.sv
// Raster timing generator: registered DE, {vsync,hsync}, coordinates and
// line/frame strobes. Optional colour bars under IBIS_VIDEO_TIMING_PATTERN_EN.
module ibis_video_timing
  import ibis_video_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
  ibis_video_timing_if.master  vid
);

  localparam int   H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam logic HPOL    = 1'(H_SYNC_POL);
  localparam logic VPOL    = 1'(V_SYNC_POL);

  logic [11:0] h_cnt, v_cnt;
  region_e     h_region, v_region;
  logic        h_wrap;

  assign h_wrap = enable && (h_cnt == 12'(H_TOTAL - 1));

  ibis_video_axis_counter #(
    .A_W(H_ACTIVE), .F_W(H_FRONT), .S_W(H_SYNC), .B_W(H_BACK)
  ) u_h (
    .clk_i(aclk), .rst_i(areset), .adv_i(enable),
    .cnt_o(h_cnt), .region_o(h_region)
  );

  ibis_video_axis_counter #(
    .A_W(V_ACTIVE), .F_W(V_FRONT), .S_W(V_SYNC), .B_W(V_BACK)
  ) u_v (
    .clk_i(aclk), .rst_i(areset), .adv_i(h_wrap),
    .cnt_o(v_cnt), .region_o(v_region)
  );

  logic        de_q, de_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        ls_q, ls_d, fs_q, fs_d;

  // Decode from the pre-increment position; registers below give 1-cycle latency
  always_comb begin
    de_d               = (h_region == ACTIVE) && (v_region == ACTIVE);
    ctrl_d             = '0;
    ctrl_d[CTRL_HSYNC] = (h_region == SYNC) ? HPOL : ~HPOL;
    ctrl_d[CTRL_VSYNC] = (v_region == SYNC) ? VPOL : ~VPOL;
    x_d                = de_d ? h_cnt : x_q;
    y_d                = de_d ? v_cnt : y_q;
    ls_d               = (h_cnt == 12'd0) && (v_region == ACTIVE);
    fs_d               = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      de_q   <= 1'b0;
      ctrl_q <= {~VPOL, ~HPOL};
      x_q    <= '0;
      y_q    <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else if (enable) begin
      de_q   <= de_d;
      ctrl_q <= ctrl_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign vid.data_enable = de_q;
  assign vid.control     = ctrl_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;

`ifdef IBIS_VIDEO_TIMING_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [23:0] rgb_q, rgb_d;
  logic [11:0] bar;

  // Any remainder pixels past the eighth bar stay in the last (black) bar
  always_comb begin
    bar   = h_cnt / 12'(BAR_W);
    rgb_d = de_d ? bar_colour((bar > 12'd7) ? 3'd7 : bar[2:0]) : 24'h000000;
  end

  always_ff @(posedge aclk) begin
    if (areset)      rgb_q <= '0;
    else if (enable) rgb_q <= rgb_d;
  end

  assign vid.rgb = rgb_q;
`endif

endmodule

// File: doc/ibis_video_timing.md
IBIS_VIDEO_TIMING -- requirements
Module: ibis_video_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48, giving horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, giving vertical widths in lines.
REQ-004 SHALL have parameters H_SYNC_POL 0 and V_SYNC_POL 0, giving the asserted sync level (0 = active-low).
REQ-005 SHALL have port aclk, input, 1 bit, sole clock.
REQ-006 SHALL have port areset, input, 1 bit; one clock, reset synchronous and active-high.
REQ-007 SHALL have port enable, input, 1 bit, pixel strobe; state advances only when high.
REQ-008 SHALL have port data_enable, output, 1 bit, high in the active region; drives the encoder data_enable.
REQ-009 SHALL have port control, output, 2 bits, {vsync, hsync}; drives the blue-channel encoder control.
REQ-010 SHALL have ports x and y, outputs, 12 bits each, giving the current active-pixel coordinates.
REQ-011 SHALL have ports line_start and frame_start, outputs, 1 bit each, single-strobe markers.

Function
REQ-012 SHALL keep h_count 0..H_TOTAL-1 and v_count 0..V_TOTAL-1, where H_TOTAL and V_TOTAL are the sums of the four region widths.
REQ-013 On enable, h_count SHALL increment and wrap to 0 after H_TOTAL-1; v_count SHALL increment only on that wrap and SHALL wrap to 0 after V_TOTAL-1.
REQ-014 Region order per axis SHALL be ACTIVE, FRONT, SYNC, BACK, held in a 4-state FSM per axis that transitions when the region's width is exhausted.
REQ-015 Outputs SHALL be registered and update only on enable cycles, reflecting the counter values before that cycle's increment; latency is 1 enabled cycle.
REQ-016 data_enable SHALL be 1 iff h_count < H_ACTIVE and v_count < V_ACTIVE.
REQ-017 hsync SHALL equal H_SYNC_POL iff h_count is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], else its inverse; vsync SHALL follow the same rule on v_count.
REQ-018 x and y SHALL equal h_count and v_count while data_enable is 1, and SHALL hold their last values otherwise.
REQ-019 line_start SHALL be high for exactly one enabled cycle, when h_count == 0 and the line is active.
REQ-020 frame_start SHALL be high for exactly one enabled cycle, when h_count == 0 and v_count == 0.
REQ-021 When enable is low, all outputs and counters SHALL hold.

Reset
REQ-022 areset SHALL clear both counters and FSMs to ACTIVE at position 0, and SHALL clear data_enable, line_start and frame_start to 0, x and y to 0, and control to {~V_SYNC_POL, ~H_SYNC_POL}.
REQ-023 areset SHALL take priority over enable; a mid-frame reset SHALL restart the frame, so the first enabled cycle after reset emits frame_start.

Configuration
REQ-024 With IBIS_VIDEO_TIMING_PATTERN_EN defined, the block SHALL add a 24-bit rgb output carrying 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black), registered and aligned with data_enable, and 0 outside active.
REQ-025 Without IBIS_VIDEO_TIMING_PATTERN_EN, the rgb port and its logic SHALL be absent.

Structure
REQ-026 Package ibis_video_pkg SHALL hold the region enum (ACTIVE, FRONT, SYNC, BACK), the control-bit index constants, and the 640x480 default timing constants.
REQ-027 One sub-module, ibis_video_axis_counter, SHALL implement counter and region FSM for one axis, instanced for H and for V (the V instance advanced by the H wrap).

Verification
REQ-028 Reset, then 800 enable pulses -> 640 cycles with data_enable=1 and x=0..639; hsync=0 for h 656..751, otherwise 1.
REQ-029 Full frame of 420000 enables -> vsync=0 only on lines 490..491; exactly 1 frame_start and 480 line_start pulses.
REQ-030 enable toggled 1/0 alternately -> outputs are identical to the continuous run when sampled on enabled cycles, and hold on others.
REQ-031 areset asserted at h=300, v=200 -> next cycle control=2'b11, data_enable=0; the first enabled cycle after reset gives frame_start=1.
REQ-032 H_SYNC_POL=1, V_SYNC_POL=1 -> control resets to 2'b00 and hsync=1 only in h 656..751.
REQ-033 With IBIS_VIDEO_TIMING_PATTERN_EN: x=0 -> rgb=24'hFFFFFF; x=80 -> 24'hFFFF00; x=639 -> 24'h000000; blanking -> 0.
